logic_result_buffer: RTL and testbench

- Registered output stage directly downstream of the 32-bit bitwise logic unit (AND/OR/XOR results).
- Captures each valid result together with its derived status flags into a small FIFO.
- Presents results to the writeback/consumer side through a valid/ready handshake.
- Counts delivered results.

---
 rtl/logic_result_buffer_pkg.sv | 27 ++
 rtl/logic_result_buffer_if.sv | 28 ++
 rtl/result_flag_gen.sv | 20 ++
 rtl/logic_result_buffer.sv | 110 +++++++++++
 tb/tb_logic_result_buffer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_result_buffer_pkg.sv
// Shared types for the logic-unit result buffer.
//   LRB_WIDTH      : default data width of a logic result
//   result_flags_t : status flags derived from a result {zero, neg, parity}
//   result_entry_t : one stored FIFO entry {data, flags}
//   occ_state_t    : occupancy state of the buffer
package logic_result_buffer_pkg;

    localparam int LRB_WIDTH = 32;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } result_flags_t;

    typedef struct packed {
        logic [LRB_WIDTH-1:0] data;
        result_flags_t        flags;
    } result_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/logic_result_buffer_if.sv
// Handshake bundle between the logic unit, the result buffer and the consumer.
//   in_valid/in_data/in_ready           : upstream push channel
//   out_valid/out_ready/out_data/flags  : downstream pop channel
//   slave  : the buffer side
//   master : the environment side (logic unit + consumer)
interface logic_result_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, out_parity
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, out_parity
    );
endinterface

// File: rtl/result_flag_gen.sv
// Combinational status-flag generator for a logic-unit result.
//   in_data : result word
//   flags   : zero (word == 0), neg (MSB), parity (1 = odd number of ones)
module result_flag_gen
    import logic_result_buffer_pkg::*;
#(
    parameter int WIDTH = LRB_WIDTH
) (
    input  logic [WIDTH-1:0] in_data,
    output result_flags_t    flags
);

    always_comb begin
        flags        = '0;
        flags.zero   = ~|in_data;
        flags.neg    = in_data[WIDTH-1];
        flags.parity = ^in_data;
    end

endmodule

// File: rtl/logic_result_buffer.sv
// Registered output stage after the bitwise logic unit.
// Results are pushed with precomputed flags into a DEPTH-entry FIFO and
// delivered through a valid/ready handshake; popped results are counted.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : handshake bundle (slave side)
//   count : results popped since reset, wraps at 2^CNT_W
//
// state       | meaning
// OCC_EMPTY   | no entries; out_valid low, in_ready high
// OCC_PARTIAL | 0 < occupancy < DEPTH; both valid and ready high
// OCC_FULL    | occupancy == DEPTH; in_ready low
module logic_result_buffer
    import logic_result_buffer_pkg::*;
#(
    parameter int WIDTH = LRB_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    logic_result_buffer_if.slave  bus,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem_data  [DEPTH];
    result_flags_t    mem_flags [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    occ_state_t       state;

    result_flags_t    in_flags;
    result_flags_t    head_flags;
    logic             out_valid_i;
    logic             in_ready_i;
    logic             push;
    logic             pop;

    result_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .in_data (bus.in_data),
        .flags   (in_flags)
    );

    // Handshake qualifiers depend only on the registered state (plus reset,
    // which keeps in_ready low during the reset cycles themselves).
    assign out_valid_i = (state != OCC_EMPTY);
    assign in_ready_i  = !reset && (state != OCC_FULL);
    assign push        = bus.in_valid && in_ready_i;
    assign pop         = out_valid_i && bus.out_ready;

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            state  <= OCC_EMPTY;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count + CNT_W'(1);
            end
            occ <= occ_next;
            if (occ_next == '0) begin
                state <= OCC_EMPTY;
            end else if (occ_next == FULL_LVL) begin
                state <= OCC_FULL;
            end else begin
                state <= OCC_PARTIAL;
            end
        end
    end

    // Storage is not cleared by reset; stale entries are unreachable because
    // occupancy is zeroed and the outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= bus.in_data;
            mem_flags[wr_ptr] <= in_flags;
        end
    end

    assign head_flags     = mem_flags[rd_ptr];
    assign bus.in_ready   = in_ready_i;
    assign bus.out_valid  = out_valid_i;
    assign bus.out_data   = out_valid_i ? mem_data[rd_ptr] : '0;
    assign bus.out_zero   = out_valid_i & head_flags.zero;
    assign bus.out_neg    = out_valid_i & head_flags.neg;
    assign bus.out_parity = out_valid_i & head_flags.parity;

endmodule

// File: tb/tb_logic_result_buffer.sv
module tb_logic_result_buffer;
    import logic_result_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] count;
    logic [3:0]  count2;

    logic_result_buffer_if #(.WIDTH(32)) bus ();
    logic_result_buffer_if #(.WIDTH(32)) bus2 ();

    logic_result_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    logic_result_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2),
        .count (count2)
    );

    always #5 clk = ~clk;

    int            vecs = 0;
    int            errs = 0;
    result_flags_t drv_flags;
    result_entry_t sb[$];

    // Reference flag model for the generated streaming pattern.
    function automatic result_flags_t ref_flags(input logic [31:0] d);
        result_flags_t f;
        int ones;
        ones = 0;
        for (int b = 0; b < 32; b++) ones += int'(d[b]);
        f.zero   = (d == 32'h0);
        f.neg    = d[31];
        f.parity = (ones % 2) == 1;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Scoreboard: record accepted pushes, compare every completed pop.
    always @(negedge clk) begin
        result_entry_t exp_e;
        result_entry_t got_e;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                vecs++;
                got_e = {bus.out_data, bus.out_zero, bus.out_neg, bus.out_parity};
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL pop_unexpected: got %h expected no pop", got_e);
                end else begin
                    exp_e = sb.pop_front();
                    if (got_e !== exp_e) begin
                        errs++;
                        $display("FAIL pop_entry: got data %h flags %b expected data %h flags %b",
                                 got_e.data, got_e.flags, exp_e.data, exp_e.flags);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({bus.in_data, drv_flags});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b0;
        drv_flags      = '0;

        // 1. reset then idle
        at_neg();
        chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            at_neg();
            chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
            chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
            chk("idle_out_data", bus.out_data, 32'd0);
            chk("idle_count", 32'(count), 32'd0);
            step();
        end

        // 2. single zero result
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0000;
        drv_flags    = 3'b100;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        at_neg();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_zero", 32'(bus.out_zero), 32'd1);
        chk("single_neg", 32'(bus.out_neg), 32'd0);
        chk("single_parity", 32'(bus.out_parity), 32'd0);
        step();
        bus.out_ready = 1'b0;
        at_neg();
        chk("single_count", 32'(count), 32'd1);
        chk("single_drained", 32'(bus.out_valid), 32'd0);
        chk("gated_data", bus.out_data, 32'd0);
        chk("gated_neg", 32'(bus.out_neg), 32'd0);
        step();

        // 3. fill and stall
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h8000_0001;
        drv_flags    = 3'b010;
        step();
        bus.in_data  = 32'h0000_0007;
        drv_flags    = 3'b001;
        step();
        bus.in_data  = 32'hDEAD_BEEF;
        drv_flags    = 3'b010;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("full_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_data", bus.out_data, 32'h8000_0001);
            chk("stall_neg", 32'(bus.out_neg), 32'd1);
            chk("stall_parity", 32'(bus.out_parity), 32'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        at_neg();
        chk("drain1_data", bus.out_data, 32'h8000_0001);
        step();
        at_neg();
        chk("drain2_data", bus.out_data, 32'h0000_0007);
        chk("drain2_parity", 32'(bus.out_parity), 32'd1);
        step();
        bus.out_ready = 1'b0;
        at_neg();
        chk("fill_count", 32'(count), 32'd3);
        chk("third_push_dropped", 32'(bus.out_valid), 32'd0);
        step();

        // 5. full push + pop in the same cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_00F0;
        drv_flags    = 3'b000;
        step();
        bus.in_data  = 32'hFFFF_FFFF;
        drv_flags    = 3'b010;
        step();
        bus.in_data   = 32'h1234_5678;
        drv_flags     = 3'b001;
        bus.out_ready = 1'b1;
        at_neg();
        chk("fullpp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fullpp_head", bus.out_data, 32'h0000_00F0);
        step();
        at_neg();
        chk("fullpp_ready_back", 32'(bus.in_ready), 32'd1);
        chk("fullpp_head2", bus.out_data, 32'hFFFF_FFFF);
        step();
        bus.in_valid = 1'b0;
        at_neg();
        chk("fullpp_late_push", bus.out_data, 32'h1234_5678);
        chk("fullpp_late_parity", 32'(bus.out_parity), 32'd1);
        step();
        bus.out_ready = 1'b0;
        at_neg();
        chk("fullpp_count", 32'(count), 32'd6);
        chk("fullpp_empty", 32'(bus.out_valid), 32'd0);
        step();

        // 4. streaming, crossing the sign boundary at i = 64
        for (int i = 0; i < 100; i++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.in_data   = 32'h7FFF_FFC0 + 32'(i);
            drv_flags     = ref_flags(bus.in_data);
            at_neg();
            if (i > 0) begin
                chk("stream_valid", 32'(bus.out_valid), 32'd1);
                chk("stream_ready", 32'(bus.in_ready), 32'd1);
            end
            step();
        end
        bus.in_valid = 1'b0;
        at_neg();
        chk("stream_last_data", bus.out_data, 32'h8000_0023);
        step();
        bus.out_ready = 1'b0;
        at_neg();
        chk("stream_count", 32'(count), 32'd106);
        chk("stream_empty", 32'(bus.out_valid), 32'd0);
        step();

        // 6a. reset with one entry buffered; push/pop in reset cycle ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0005;
        drv_flags    = 3'b000;
        step();
        bus.in_valid = 1'b0;
        at_neg();
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        step();
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00AB;
        bus.out_ready = 1'b1;
        at_neg();
        chk("midreset_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        at_neg();
        chk("post_reset_valid", 32'(bus.out_valid), 32'd0);
        chk("post_reset_count", 32'(count), 32'd0);
        chk("post_reset_data", bus.out_data, 32'd0);
        chk("post_reset_ready", 32'(bus.in_ready), 32'd1);
        step();

        // 6b. 4-bit counter wrap on the second instance
        for (int i = 0; i < 16; i++) begin
            bus2.in_valid  = 1'b1;
            bus2.out_ready = 1'b1;
            bus2.in_data   = 32'(i);
            step();
        end
        bus2.in_valid = 1'b0;
        at_neg();
        chk("wrap_count_max", 32'(count2), 32'd15);
        chk("wrap_head", bus2.out_data, 32'd15);
        step();
        bus2.out_ready = 1'b0;
        at_neg();
        chk("wrap_count_zero", 32'(count2), 32'd0);
        chk("wrap_empty", 32'(bus2.out_valid), 32'd0);
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
